// File: rtl/const_q_checker.sv
// rtl/const_q_checker.sv - checks that a single-bit register output settles to and holds a constant
module const_q_checker #(
  parameter logic EXP_VAL    = 1'b1,
  parameter int   STABLE_CYC = 2,
  parameter int   SETTLE_CYC = 8,
  parameter int   CNT_W      = 4,
  parameter int   ERR_W      = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             q_in,
  input  logic             clr,
  output logic             busy,
  output logic             locked,
  output logic             fail,
  output logic [ERR_W-1:0] err_cnt
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_LOCKED = 2'd2,
    S_FAIL   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] STAB_TGT   = CNT_W'(STABLE_CYC);
  localparam logic [CNT_W-1:0] SETTLE_TGT = CNT_W'(SETTLE_CYC);

  state_t           state;
  logic [CNT_W-1:0] stab_cnt;
  logic [CNT_W-1:0] cyc_cnt;
  logic             match;
  logic [CNT_W-1:0] stab_nxt;
  logic [CNT_W-1:0] cyc_nxt;
  logic [ERR_W-1:0] err_inc;

  assign match    = (q_in == EXP_VAL);
  assign stab_nxt = match ? stab_cnt + CNT_W'(1) : '0;
  assign cyc_nxt  = cyc_cnt + CNT_W'(1);
  assign err_inc  = (err_cnt == '1) ? err_cnt : err_cnt + ERR_W'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      stab_cnt <= '0;
      cyc_cnt  <= '0;
      err_cnt  <= '0;
    end else if (clr) begin
      // Restart wins over anything this edge's sample would have caused.
      state    <= S_SETTLE;
      stab_cnt <= '0;
      cyc_cnt  <= '0;
      err_cnt  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          state    <= S_SETTLE;
          stab_cnt <= '0;
          cyc_cnt  <= '0;
        end
        S_SETTLE: begin
          stab_cnt <= stab_nxt;
          cyc_cnt  <= cyc_nxt;
          if (stab_nxt == STAB_TGT)
            state <= S_LOCKED;
          else if (cyc_nxt == SETTLE_TGT)
            state <= S_FAIL;
        end
        S_LOCKED: begin
          if (!match) begin
            state   <= S_FAIL;
            err_cnt <= err_inc;
          end
        end
        S_FAIL: begin
          if (!match)
            err_cnt <= err_inc;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy   = (state == S_SETTLE);
  assign locked = (state == S_LOCKED);
  assign fail   = (state == S_FAIL);

endmodule
